// File: rtl/sram_bank_ctrl.sv
// SRAM bank controller: maps a wide request onto a grid of SRAM macros and returns
// one in-order response per request through a latency pipeline and credit-limited FIFO.
module sram_bank_ctrl #(
    parameter int   AddrWidth     = 48,
    parameter int   DataWidth     = 512,
    parameter int   SramDataWidth = 256,
    parameter int   SramNumWords  = 512,
    parameter int   NumBankRows   = 4,
    parameter int   SramLatency   = 1,
    parameter int   RspDepth      = 2,
    parameter logic Interleave    = 1'b0
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              req_i,
    output logic                                              gnt_o,
    input  logic                                              we_i,
    input  logic [AddrWidth-1:0]                              addr_i,
    input  logic [DataWidth-1:0]                              wdata_i,
    input  logic [DataWidth/8-1:0]                            be_i,
    output logic                                              rvalid_o,
    input  logic                                              rready_i,
    output logic [DataWidth-1:0]                              rdata_o,
    output logic                                              err_o,
    output logic                                              is_write_o,
    output logic [NumBankRows*(DataWidth/SramDataWidth)-1:0]  sram_req_o,
    output logic                                              sram_we_o,
    output logic [$clog2(SramNumWords)-1:0]                   sram_addr_o,
    output logic [DataWidth-1:0]                              sram_wdata_o,
    output logic [DataWidth/8-1:0]                            sram_be_o,
    input  logic [NumBankRows*DataWidth-1:0]                  sram_rdata_i
);

    localparam int NumBanksPerWord = DataWidth / SramDataWidth;
    localparam int ByteBits = $clog2(SramDataWidth / 8) + $clog2(NumBanksPerWord);
    localparam int WordBits = $clog2(SramNumWords);
    localparam int RowBits  = $clog2(NumBankRows);
    localparam int RowW     = (RowBits > 0) ? RowBits : 1;
    localparam int TopBit   = ByteBits + WordBits + RowBits;
    localparam int CntW     = $clog2(RspDepth + 1);
    localparam int PtrW     = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    if (RspDepth < SramLatency + 1) begin : g_depth_check
        $error("RspDepth must be at least SramLatency+1");
    end

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(RspDepth - 1)) begin
            return '0;
        end else begin
            return p + PtrW'(1);
        end
    endfunction

    logic                   accept_s, oor_s, fire_s, push_s, pop_s, fifo_empty_s;
    logic [RowW-1:0]        row_s, row_raw_s;
    logic [WordBits-1:0]    word_s;
    logic [CntW-1:0]        credit_r, fifo_cnt_r;
    logic [SramLatency-1:0] pipe_valid_r, pipe_we_r, pipe_err_r;
    logic [RowW-1:0]        pipe_row_r [SramLatency];
    logic                   exit_valid_s, exit_we_s, exit_err_s;
    logic [RowW-1:0]        exit_row_s;
    logic [DataWidth-1:0]   exit_data_s;
    logic [DataWidth-1:0]   fifo_data_r [RspDepth];
    logic [RspDepth-1:0]    fifo_we_r, fifo_err_r;
    logic [PtrW-1:0]        rptr_r, wptr_r;

    assign gnt_o    = rst_ni && (credit_r < CntW'(RspDepth));
    assign accept_s = req_i && gnt_o;

    // Address decode: range check plus row/word split for either interleave mode.
    always_comb begin
        oor_s     = ((addr_i >> TopBit) != '0);
        row_raw_s = '0;
        word_s    = '0;
        if (Interleave) begin
            row_raw_s = addr_i[ByteBits +: RowW];
            word_s    = addr_i[ByteBits + RowBits +: WordBits];
        end else begin
            word_s    = addr_i[ByteBits +: WordBits];
            row_raw_s = addr_i[ByteBits + WordBits +: RowW];
        end
        row_s = (RowBits == 0) ? '0 : row_raw_s;
    end

    // Macro strobes: every bank of the selected row fires together on an in-range accept.
    always_comb begin
        sram_req_o = '0;
        sram_we_o  = 1'b0;
        if (accept_s && !oor_s) begin
            sram_req_o[int'(row_s) * NumBanksPerWord +: NumBanksPerWord] = '1;
            sram_we_o = we_i;
        end else begin
            sram_req_o = '0;
            sram_we_o  = 1'b0;
        end
    end

    assign sram_addr_o  = word_s;
    assign sram_wdata_o = wdata_i;
    assign sram_be_o    = be_i;

    // Request attributes travel alongside the macro read latency.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pipe_valid_r <= '0;
            pipe_we_r    <= '0;
            pipe_err_r   <= '0;
            for (int i = 0; i < SramLatency; i++) begin
                pipe_row_r[i] <= '0;
            end
        end else begin
            pipe_valid_r[0] <= accept_s;
            pipe_we_r[0]    <= we_i;
            pipe_err_r[0]   <= oor_s;
            pipe_row_r[0]   <= row_s;
            for (int i = 1; i < SramLatency; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_we_r[i]    <= pipe_we_r[i-1];
                pipe_err_r[i]   <= pipe_err_r[i-1];
                pipe_row_r[i]   <= pipe_row_r[i-1];
            end
        end
    end

    assign exit_valid_s = pipe_valid_r[SramLatency-1];
    assign exit_we_s    = pipe_we_r[SramLatency-1];
    assign exit_err_s   = pipe_err_r[SramLatency-1];
    assign exit_row_s   = pipe_row_r[SramLatency-1];

    // Writes and errors carry no data; reads take the delayed row's slice of the macro bus.
    always_comb begin
        exit_data_s = '0;
        if (exit_we_s || exit_err_s) begin
            exit_data_s = '0;
        end else begin
            exit_data_s = sram_rdata_i[int'(exit_row_s) * DataWidth +: DataWidth];
        end
    end

    assign fifo_empty_s = (fifo_cnt_r == '0);
    assign push_s       = exit_valid_s && !(fifo_empty_s && rready_i);
    assign pop_s        = !fifo_empty_s && rready_i;
    assign fire_s       = rvalid_o && rready_i;

    // Response select: FIFO head has priority, otherwise the pipeline output bypasses.
    always_comb begin
        rvalid_o   = 1'b0;
        rdata_o    = '0;
        err_o      = 1'b0;
        is_write_o = 1'b0;
        if (!rst_ni) begin
            rvalid_o = 1'b0;
        end else if (!fifo_empty_s) begin
            rvalid_o   = 1'b1;
            rdata_o    = fifo_data_r[rptr_r];
            err_o      = fifo_err_r[rptr_r];
            is_write_o = fifo_we_r[rptr_r];
        end else if (exit_valid_s) begin
            rvalid_o   = 1'b1;
            rdata_o    = exit_data_s;
            err_o      = exit_err_s;
            is_write_o = exit_we_s;
        end else begin
            rvalid_o = 1'b0;
        end
    end

    // Credits count every request between accept and response handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            credit_r <= '0;
        end else if (accept_s && !fire_s) begin
            credit_r <= credit_r + CntW'(1);
        end else if (fire_s && !accept_s) begin
            credit_r <= credit_r - CntW'(1);
        end else begin
            credit_r <= credit_r;
        end
    end

    // Response FIFO; the credit limit guarantees room for everything in the pipeline.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rptr_r     <= '0;
            wptr_r     <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) begin
                fifo_data_r[wptr_r] <= exit_data_s;
                fifo_we_r[wptr_r]   <= exit_we_s;
                fifo_err_r[wptr_r]  <= exit_err_s;
                wptr_r              <= ptr_inc(wptr_r);
            end
            if (pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CntW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CntW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Scoreboard bench for sram_bank_ctrl: default, interleaved and long-latency instances
// driven by directed vectors against behavioural SRAM models.
module tb_sram_bank_ctrl;

    localparam int DW = 512;
    localparam int AW = 48;
    localparam int NR = 4;
    localparam int NB = 2;
    localparam logic [DW-1:0] JUNK = {16{32'hDEAD_BEEF}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          wr;
        int            cyc;
    } rsp_t;
    rsp_t m_q[$];
    rsp_t l_q[$];

    // main (defaults), interleaved and long-latency instance signals
    logic m_req, m_gnt, m_we, m_rvalid, m_rready, m_err, m_isw, m_swe;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata, m_swdata;
    logic [63:0] m_be, m_sbe;
    logic [7:0] m_sreq;
    logic [8:0] m_saddr;
    logic [NR*DW-1:0] m_srdata;

    logic i_req, i_gnt, i_we, i_rvalid, i_rready, i_err, i_isw, i_swe;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata, i_rdata, i_swdata;
    logic [63:0] i_be, i_sbe;
    logic [7:0] i_sreq;
    logic [8:0] i_saddr;
    logic [NR*DW-1:0] i_srdata;

    logic l_req, l_gnt, l_we, l_rvalid, l_rready, l_err, l_isw, l_swe;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata, l_swdata;
    logic [63:0] l_be, l_sbe;
    logic [7:0] l_sreq;
    logic [8:0] l_saddr;
    logic [NR*DW-1:0] l_srdata;

    sram_bank_ctrl u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(m_req), .gnt_o(m_gnt), .we_i(m_we),
        .addr_i(m_addr), .wdata_i(m_wdata), .be_i(m_be), .rvalid_o(m_rvalid),
        .rready_i(m_rready), .rdata_o(m_rdata), .err_o(m_err), .is_write_o(m_isw),
        .sram_req_o(m_sreq), .sram_we_o(m_swe), .sram_addr_o(m_saddr),
        .sram_wdata_o(m_swdata), .sram_be_o(m_sbe), .sram_rdata_i(m_srdata)
    );

    sram_bank_ctrl #(.Interleave(1'b1)) u_il (
        .clk_i(clk), .rst_ni(rst_n), .req_i(i_req), .gnt_o(i_gnt), .we_i(i_we),
        .addr_i(i_addr), .wdata_i(i_wdata), .be_i(i_be), .rvalid_o(i_rvalid),
        .rready_i(i_rready), .rdata_o(i_rdata), .err_o(i_err), .is_write_o(i_isw),
        .sram_req_o(i_sreq), .sram_we_o(i_swe), .sram_addr_o(i_saddr),
        .sram_wdata_o(i_swdata), .sram_be_o(i_sbe), .sram_rdata_i(i_srdata)
    );

    sram_bank_ctrl #(.SramLatency(3), .RspDepth(4)) u_lat (
        .clk_i(clk), .rst_ni(rst_n), .req_i(l_req), .gnt_o(l_gnt), .we_i(l_we),
        .addr_i(l_addr), .wdata_i(l_wdata), .be_i(l_be), .rvalid_o(l_rvalid),
        .rready_i(l_rready), .rdata_o(l_rdata), .err_o(l_err), .is_write_o(l_isw),
        .sram_req_o(l_sreq), .sram_we_o(l_swe), .sram_addr_o(l_saddr),
        .sram_wdata_o(l_swdata), .sram_be_o(l_sbe), .sram_rdata_i(l_srdata)
    );

    assign i_srdata = '0;

    function automatic logic [DW-1:0] pat(input int row, input int word);
        logic [DW-1:0] p;
        for (int k = 0; k < 16; k++) begin
            p[k*32 +: 32] = 32'h5A00_0000 ^ (32'(row) << 16) ^ 32'(word) ^ (32'(k) << 24);
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Default SRAM model: latency 1, unwritten words read back as pat(row, word).
    logic [DW-1:0] mem [int];
    always @(posedge clk) begin : m_sram
        logic [DW-1:0] w;
        int key;
        for (int r = 0; r < NR; r++) begin
            m_srdata[r*DW +: DW] <= JUNK;
            if (m_sreq[r*NB] || m_sreq[r*NB+1]) begin
                key = r * 512 + int'(m_saddr);
                w = mem.exists(key) ? mem[key] : pat(r, int'(m_saddr));
                if (m_swe) begin
                    for (int b = 0; b < 64; b++) begin
                        if (m_sbe[b] && m_sreq[r*NB + b/32]) w[b*8 +: 8] = m_swdata[b*8 +: 8];
                    end
                    mem[key] = w;
                end else begin
                    m_srdata[r*DW +: DW] <= w;
                end
            end
        end
    end

    // Latency-3 read-only SRAM model.
    logic [NR*DW-1:0] l_s0, l_s1;
    always @(posedge clk) begin
        for (int r = 0; r < NR; r++) begin
            l_s0[r*DW +: DW] <= l_sreq[r*NB] ? pat(r, int'(l_saddr)) : JUNK;
        end
        l_s1 <= l_s0;
        l_srdata <= l_s1;
    end

    // Monitor: pop and compare on every response handshake of the default instance.
    always @(negedge clk) begin : m_mon
        rsp_t e;
        if (rst_n && m_rvalid && m_rready) begin
            if (m_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL m_unexpected: got rvalid=1 want no response");
            end else begin
                e = m_q.pop_front();
                chk("m_rdata", m_rdata, e.data);
                chk("m_err", m_err, e.err);
                chk("m_is_write", m_isw, e.wr);
                if (e.cyc >= 0) chk("m_latency", cyc, e.cyc);
            end
        end else if (rst_n && !m_rvalid) begin
            chk("m_idle_rdata", m_rdata, '0);
            chk("m_idle_err", m_err, 1'b0);
            chk("m_idle_isw", m_isw, 1'b0);
        end
    end

    // Monitor for the latency-3 instance.
    always @(negedge clk) begin : l_mon
        rsp_t e;
        if (rst_n && l_rvalid && l_rready) begin
            if (l_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL l_unexpected: got rvalid=1 want no response");
            end else begin
                e = l_q.pop_front();
                chk("l_rdata", l_rdata, e.data);
                chk("l_err", l_err, e.err);
                chk("l_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #50000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    logic [DW-1:0] w1, w2, tmp;
    logic [7:0] il_sreq [5];
    logic [8:0] il_word [5];
    logic [AW-1:0] il_addr [5];

    initial begin
        w1 = {8{64'h0123_4567_89AB_CDEF}};
        w2 = {16{32'hCAFE_F00D}};
        il_addr = '{48'h00, 48'h40, 48'h80, 48'hC0, 48'h140};
        il_sreq = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h0C};
        il_word = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd1};
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '1; m_rready = 1'b1;
        i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_be = '1; i_rready = 1'b1;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; l_be = '1; l_rready = 1'b1;

        // reset state
        step(); step();
        @(negedge clk);
        chk("rst_gnt", m_gnt, 1'b0);
        chk("rst_rvalid", m_rvalid, 1'b0);
        chk("rst_sram_req", m_sreq, 8'h00);
        chk("rst_sram_we", m_swe, 1'b0);
        chk("rst_err", m_err, 1'b0);
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk("rel_gnt", m_gnt, 1'b1);

        // write 0x0 full be, then read it back plus other rows
        step(); m_req = 1'b1; m_we = 1'b1; m_addr = 48'h0; m_wdata = w1; m_be = '1;
        @(negedge clk);
        chk("wr0_sram_req", m_sreq, 8'h03);
        chk("wr0_sram_we", m_swe, 1'b1);
        chk("wr0_sram_addr", m_saddr, 9'd0);
        m_q.push_back('{'0, 1'b0, 1'b1, cyc + 1});
        step(); m_we = 1'b0; m_addr = 48'h0;
        @(negedge clk);
        chk("rd0_sram_req", m_sreq, 8'h03);
        chk("rd0_sram_we", m_swe, 1'b0);
        chk("rd0_gnt", m_gnt, 1'b1);
        m_q.push_back('{w1, 1'b0, 1'b0, cyc + 1});
        step(); m_we = 1'b1; m_addr = 48'h80C0; m_wdata = w2; m_be = {32'h0, 32'hFFFF_FFFF};
        @(negedge clk);
        chk("wrp_sram_req", m_sreq, 8'h0C);
        chk("wrp_sram_addr", m_saddr, 9'd3);
        chk("wrp_sram_be", m_sbe, {32'h0, 32'hFFFF_FFFF});
        m_q.push_back('{'0, 1'b0, 1'b1, cyc + 1});
        step(); m_we = 1'b0; m_be = '1;
        tmp = pat(1, 3);
        tmp[255:0] = w2[255:0];
        m_q.push_back('{tmp, 1'b0, 1'b0, cyc + 1});
        step(); m_addr = 48'h10140;
        @(negedge clk);
        chk("rd2_sram_req", m_sreq, 8'h30);
        chk("rd2_sram_addr", m_saddr, 9'd5);
        m_q.push_back('{pat(2, 5), 1'b0, 1'b0, cyc + 1});
        step(); m_req = 1'b0;
        step(); step();

        // backpressure: two grants, third held off until a response drains
        step(); m_rready = 1'b0; m_req = 1'b1; m_addr = 48'h40;
        @(negedge clk);
        chk("bp_gnt1", m_gnt, 1'b1);
        m_q.push_back('{pat(0, 1), 1'b0, 1'b0, -1});
        step(); m_addr = 48'h8000;
        @(negedge clk);
        chk("bp_gnt2", m_gnt, 1'b1);
        chk("bp_rvalid", m_rvalid, 1'b1);
        chk("bp_hold_a", m_rdata, pat(0, 1));
        m_q.push_back('{pat(1, 0), 1'b0, 1'b0, -1});
        step(); m_addr = 48'h10000;
        @(negedge clk);
        chk("bp_gnt3", m_gnt, 1'b0);
        chk("bp_no_sram_req", m_sreq, 8'h00);
        chk("bp_hold_b", m_rdata, pat(0, 1));
        step(); m_rready = 1'b1;
        @(negedge clk);
        chk("bp_gnt_full", m_gnt, 1'b0);
        step();
        @(negedge clk);
        chk("bp_gnt_back", m_gnt, 1'b1);
        m_q.push_back('{pat(2, 0), 1'b0, 1'b0, cyc + 1});
        step(); m_req = 1'b0;
        step(); step();

        // out-of-range requests and the topmost in-range word
        step(); m_req = 1'b1; m_we = 1'b0; m_addr = 48'h2_0000;
        @(negedge clk);
        chk("oor_rd_sram_req", m_sreq, 8'h00);
        chk("oor_rd_sram_we", m_swe, 1'b0);
        m_q.push_back('{'0, 1'b1, 1'b0, cyc + 1});
        step(); m_we = 1'b1; m_addr = 48'h8000_0000_0000;
        @(negedge clk);
        chk("oor_wr_sram_req", m_sreq, 8'h00);
        chk("oor_wr_sram_we", m_swe, 1'b0);
        m_q.push_back('{'0, 1'b1, 1'b1, cyc + 1});
        step(); m_we = 1'b0; m_addr = 48'h1_FFC0;
        @(negedge clk);
        chk("top_sram_req", m_sreq, 8'hC0);
        chk("top_sram_addr", m_saddr, 9'h1FF);
        m_q.push_back('{pat(3, 511), 1'b0, 1'b0, cyc + 1});
        step(); m_req = 1'b0;
        step(); step();

        // reset with two responses pending drops them
        step(); m_rready = 1'b0; m_req = 1'b1; m_addr = 48'h40;
        step(); m_addr = 48'h80;
        step(); m_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("rstp_rvalid", m_rvalid, 1'b0);
        chk("rstp_gnt", m_gnt, 1'b0);
        step(); rst_n = 1'b1; m_rready = 1'b1;
        @(negedge clk);
        chk("rstp_rel_gnt", m_gnt, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstp_no_stale", m_rvalid, 1'b0);
            step();
        end

        // interleaved row selection
        for (int i = 0; i < 5; i++) begin
            step(); i_req = 1'b1; i_addr = il_addr[i];
            @(negedge clk);
            chk("il_gnt", i_gnt, 1'b1);
            chk("il_sram_req", i_sreq, il_sreq[i]);
            chk("il_sram_addr", i_saddr, il_word[i]);
        end
        step(); i_req = 1'b0;

        // latency-3 streaming, one accept per cycle
        for (int j = 0; j < 6; j++) begin
            step(); l_req = 1'b1; l_addr = 48'(j * 64 + (j % 4) * 32768);
            l_q.push_back('{pat(j % 4, j), 1'b0, 1'b0, cyc + 3});
            @(negedge clk);
            chk("l_stream_gnt", l_gnt, 1'b1);
        end
        step(); l_req = 1'b0;
        repeat (8) step();

        chk("m_drain", 32'(m_q.size()), 32'd0);
        chk("l_drain", 32'(l_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
